// File: rtl/lcd_timing.sv
// LCD scan timing: dot/line counters, LCDC/STAT/LY/LYC registers, VBLANK and STAT interrupts.
// Latency: register writes take effect at the write edge; reads and IRQ outputs are combinational from state.
// Backpressure: none; the CPU bus is always accepted, data_ext is driven only during a register read.
module lcd_timing #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int XFER_DOTS     = 172,
  parameter int LINES_VISIBLE = 144,
  parameter int LINES_TOTAL   = 154
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  input  logic        mem_re,
  input  logic        mem_we,
  output logic        vblank_interrupt,
  output logic        lcdc_interrupt,
  output logic [1:0]  lcd_mode,
  output logic [7:0]  ly
);

  localparam logic [15:0] ADDR_LCDC = 16'hFF40;
  localparam logic [15:0] ADDR_STAT = 16'hFF41;
  localparam logic [15:0] ADDR_LY   = 16'hFF44;
  localparam logic [15:0] ADDR_LYC  = 16'hFF45;

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LY_VBL   = 8'(LINES_VISIBLE);
  localparam logic [7:0] LY_LAST  = 8'(LINES_TOTAL - 1);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  logic [7:0] lcdc_q;
  logic [3:0] stat_en_q;   // STAT bits 6:3
  logic [7:0] lyc_q;
  logic [8:0] dot_q;
  logic [7:0] ly_q;
  logic       stat_prev_q;

  logic       lcd_on;
  logic [7:0] wr_dat;
  logic       wr_lcdc;
  logic       wr_stat;
  logic       wr_ly;
  logic       wr_lyc;
  logic       lcd_turning_off;
  logic       coinc;
  logic       stat_line;
  logic [1:0] mode;
  logic       rd_hit;
  logic [7:0] rd_dat;

  assign lcd_on  = lcdc_q[7];
  assign wr_dat  = data_ext;
  assign wr_lcdc = mem_we && (addr_ext == ADDR_LCDC);
  assign wr_stat = mem_we && (addr_ext == ADDR_STAT);
  assign wr_ly   = mem_we && (addr_ext == ADDR_LY);
  assign wr_lyc  = mem_we && (addr_ext == ADDR_LYC);

  // Clearing on the write edge itself (not one cycle later) keeps ly/mode at 0
  // from the very first cycle the LCD reads as off.
  assign lcd_turning_off = wr_lcdc && !wr_dat[7];

  // CPU-visible configuration registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lcdc_q    <= 8'h00;
      stat_en_q <= 4'h0;
      lyc_q     <= 8'h00;
    end else begin
      if (wr_lcdc) lcdc_q    <= wr_dat;
      if (wr_stat) stat_en_q <= wr_dat[6:3];
      if (wr_lyc)  lyc_q     <= wr_dat;
    end
  end

  // Dot and line counters; a CPU write to LY takes priority over the advance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dot_q <= 9'd0;
      ly_q  <= 8'd0;
    end else if (wr_ly || !lcd_on || lcd_turning_off) begin
      dot_q <= 9'd0;
      ly_q  <= 8'd0;
    end else if (dot_q == DOT_LAST) begin
      dot_q <= 9'd0;
      ly_q  <= (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
    end else begin
      dot_q <= dot_q + 9'd1;
    end
  end

  // Mode decode from the current scan position
  always_comb begin
    mode = MODE_HBLANK;
    if (lcd_on) begin
      if (ly_q >= LY_VBL)        mode = MODE_VBLANK;
      else if (dot_q < OAM_END)  mode = MODE_OAM;
      else if (dot_q < XFER_END) mode = MODE_XFER;
      else                       mode = MODE_HBLANK;
    end
  end

  assign coinc = (ly_q == lyc_q);

  // STAT sources are OR-ed before edge detection, so a handoff between two
  // overlapping conditions produces no new interrupt.
  always_comb begin
    stat_line = 1'b0;
    if (mode == MODE_HBLANK && stat_en_q[0]) stat_line = 1'b1;
    if (mode == MODE_VBLANK && stat_en_q[1]) stat_line = 1'b1;
    if (mode == MODE_OAM    && stat_en_q[2]) stat_line = 1'b1;
    if (coinc               && stat_en_q[3]) stat_line = 1'b1;
  end

  // Previous STAT line level for rising-edge detection; held low while off
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_prev_q <= 1'b0;
    end else if (!lcd_on || lcd_turning_off) begin
      stat_prev_q <= 1'b0;
    end else begin
      stat_prev_q <= stat_line;
    end
  end

  assign lcdc_interrupt   = lcd_on && stat_line && !stat_prev_q;
  assign vblank_interrupt = lcd_on && (ly_q == LY_VBL) && (dot_q == 9'd0);
  assign lcd_mode         = mode;
  assign ly               = ly_q;

  // Register read mux; bus is released when no register is selected
  always_comb begin
    rd_hit = 1'b0;
    rd_dat = 8'h00;
    if (mem_re) begin
      case (addr_ext)
        ADDR_LCDC: begin rd_hit = 1'b1; rd_dat = lcdc_q; end
        ADDR_STAT: begin rd_hit = 1'b1; rd_dat = {1'b1, stat_en_q, coinc, mode}; end
        ADDR_LY:   begin rd_hit = 1'b1; rd_dat = ly_q; end
        ADDR_LYC:  begin rd_hit = 1'b1; rd_dat = lyc_q; end
        default:   begin rd_hit = 1'b0; rd_dat = 8'h00; end
      endcase
    end
  end

  assign data_ext = rd_hit ? rd_dat : 8'bz;

endmodule

// File: tb/tb_lcd_timing.sv
// Directed bench for lcd_timing: register reset values, full-frame timing table,
// STAT interrupt corner cases, LY write, LCD off/on, LYC write and async reset.
module tb_lcd_timing;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_ext = 16'h0000;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic        drv = 1'b0;
  logic [7:0]  drv_dat = 8'h00;
  wire  [7:0]  data_ext;
  logic        vblank_interrupt;
  logic        lcdc_interrupt;
  logic [1:0]  lcd_mode;
  logic [7:0]  ly;

  assign data_ext = drv ? drv_dat : 8'bz;

  lcd_timing dut (
    .clock            (clock),
    .reset            (reset),
    .addr_ext         (addr_ext),
    .data_ext         (data_ext),
    .mem_re           (mem_re),
    .mem_we           (mem_we),
    .vblank_interrupt (vblank_interrupt),
    .lcdc_interrupt   (lcdc_interrupt),
    .lcd_mode         (lcd_mode),
    .ly               (ly)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total    = 0;
  int vb_cnt   = 0;
  int lc_cnt   = 0;

  // Interrupt pulse counters, sampled mid-cycle
  always @(negedge clock) begin
    if (vblank_interrupt) vb_cnt++;
    if (lcdc_interrupt)   lc_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance n posedges, leaving time at edge+1
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One-cycle register write; consumes exactly one posedge
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addr_ext = a;
    drv_dat  = d;
    drv      = 1'b1;
    mem_we   = 1'b1;
    @(posedge clock);
    #1;
    mem_we   = 1'b0;
    drv      = 1'b0;
    addr_ext = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr_ext = a;
    mem_re   = 1'b1;
    #1;
    d        = data_ext;
    mem_re   = 1'b0;
    addr_ext = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    int         clk;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       vb;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  val;
  } rdv_t;

  vec_t vt[12];
  rdv_t rv[4];

  initial begin
    logic [7:0] d;
    int cur;
    int vb0;
    int lc0;
    int first;
    int npulse;

    // Frame timing relative to the cycle after the enabling write
    vt[0]  = '{0,     8'd0,   2'd2, 1'b0};
    vt[1]  = '{79,    8'd0,   2'd2, 1'b0};
    vt[2]  = '{80,    8'd0,   2'd3, 1'b0};
    vt[3]  = '{251,   8'd0,   2'd3, 1'b0};
    vt[4]  = '{252,   8'd0,   2'd0, 1'b0};
    vt[5]  = '{455,   8'd0,   2'd0, 1'b0};
    vt[6]  = '{456,   8'd1,   2'd2, 1'b0};
    vt[7]  = '{65663, 8'd143, 2'd0, 1'b0};
    vt[8]  = '{65664, 8'd144, 2'd1, 1'b1};
    vt[9]  = '{65665, 8'd144, 2'd1, 1'b0};
    vt[10] = '{70223, 8'd153, 2'd1, 1'b0};
    vt[11] = '{70224, 8'd0,   2'd2, 1'b0};

    rv[0] = '{16'hFF40, 8'h00};
    rv[1] = '{16'hFF41, 8'h84};
    rv[2] = '{16'hFF44, 8'h00};
    rv[3] = '{16'hFF45, 8'h00};

    #1;
    do_reset();

    // Reset values
    for (int i = 0; i < 4; i++) begin
      rd(rv[i].addr, d);
      chk($sformatf("reset read %h", rv[i].addr), d, rv[i].val);
    end
    chk("reset vblank_interrupt", vblank_interrupt, 0);
    chk("reset lcdc_interrupt", lcdc_interrupt, 0);
    chk("reset ly", ly, 0);
    chk("reset lcd_mode", lcd_mode, 0);
    // Bus released when not reading: an external driver must be seen unchanged
    addr_ext = 16'hFF41;
    drv_dat  = 8'hA5;
    drv      = 1'b1;
    #1;
    chk("idle bus not driven", data_ext, 8'hA5);
    drv      = 1'b0;
    addr_ext = 16'h0000;
    step(1);

    // Full frame
    wr(16'hFF40, 8'h91);
    cur = 0;
    vb0 = vb_cnt;
    for (int i = 0; i < 12; i++) begin
      step(vt[i].clk - cur);
      cur = vt[i].clk;
      chk($sformatf("frame ly @%0d", cur), ly, vt[i].ly);
      chk($sformatf("frame mode @%0d", cur), lcd_mode, vt[i].mode);
      chk($sformatf("frame vblank @%0d", cur), vblank_interrupt, vt[i].vb);
    end
    chk("vblank pulses per frame", vb_cnt - vb0, 1);

    // LYC coincidence interrupt only
    do_reset();
    wr(16'hFF41, 8'h40);
    wr(16'hFF45, 8'h05);
    wr(16'hFF40, 8'h91);
    lc0 = lc_cnt;
    first = -1;
    for (int t = 0; t <= 2736; t++) begin
      if (t > 0) step(1);
      if (lcdc_interrupt && first < 0) first = t;
      if (t == 2279 || t == 2380 || t == 2736) begin
        rd(16'hFF41, d);
        chk($sformatf("coinc bit @%0d", t), d[2], (t == 2380) ? 1 : 0);
      end
    end
    chk("lyc irq count", lc_cnt - lc0, 1);
    chk("lyc irq position", first, 2280);

    // HBLANK + LYC: no second edge at the mode0 -> LYC handoff
    do_reset();
    wr(16'hFF41, 8'h48);
    wr(16'hFF45, 8'h05);
    wr(16'hFF40, 8'h91);
    first  = -1;
    npulse = 0;
    for (int t = 0; t <= 2380; t++) begin
      if (t > 0) step(1);
      if (t >= 1700 && lcdc_interrupt) begin
        npulse++;
        if (first < 0) first = t;
      end
      if (t == 2280) chk("no irq at line5 entry", lcdc_interrupt, 0);
    end
    chk("handoff irq count", npulse, 1);
    chk("handoff irq position", first, 2076);

    // LY write restarts the frame
    do_reset();
    wr(16'hFF40, 8'h91);
    step(10 * 456 + 10);
    chk("ly before LY write", ly, 10);
    wr(16'hFF44, 8'h5A);
    chk("ly after LY write", ly, 0);
    chk("mode after LY write", lcd_mode, 2);
    step(455);
    chk("ly end of line 0 after LY write", ly, 0);
    chk("mode end of line 0 after LY write", lcd_mode, 0);
    step(1);
    chk("ly line 1 after LY write", ly, 1);

    // LCD off mid-line: HBLANK STAT enable must not fire while off
    step(100);
    wr(16'hFF41, 8'h08);
    wr(16'hFF40, 8'h00);
    chk("ly after off", ly, 0);
    chk("mode after off", lcd_mode, 0);
    vb0 = vb_cnt;
    lc0 = lc_cnt;
    step(300);
    chk("ly stays 0 while off", ly, 0);
    chk("no vblank while off", vb_cnt - vb0, 0);
    chk("no lcdc irq while off", lc_cnt - lc0, 0);

    // Re-enable restarts timing
    wr(16'hFF40, 8'h91);
    chk("re-enable mode", lcd_mode, 2);
    chk("re-enable ly", ly, 0);
    step(80);
    chk("re-enable mode @80", lcd_mode, 3);
    step(172);
    chk("re-enable mode @252", lcd_mode, 0);
    chk("re-enable hblank irq @252", lcdc_interrupt, 1);
    step(204);
    chk("re-enable ly @456", ly, 1);
    chk("re-enable mode @456", lcd_mode, 2);

    // LYC write makes coincidence true while on
    wr(16'hFF41, 8'h40);
    step(2 * 456 + 49);
    chk("ly before LYC write", ly, 3);
    chk("no irq before LYC write", lcdc_interrupt, 0);
    wr(16'hFF45, 8'h03);
    chk("irq after LYC write", lcdc_interrupt, 1);
    rd(16'hFF41, d);
    chk("coinc after LYC write", d[2], 1);
    step(1);
    chk("irq one cycle only", lcdc_interrupt, 0);

    // Asynchronous reset mid-frame
    step(50);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset ly", ly, 0);
    chk("async reset mode", lcd_mode, 0);
    rd(16'hFF40, d);
    chk("async reset LCDC", d, 0);
    @(negedge clock);
    reset = 1'b1;
    vb0 = vb_cnt;
    lc0 = lc_cnt;
    step(20);
    chk("no irq after reset release", (lc_cnt - lc0) + (vb_cnt - vb0), 0);
    chk("ly after reset release", ly, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
